// File: rtl/imm_target_gen_pipe.sv
// imm_target_gen_pipe: two-stage SPARC V8 immediate extractor/extender with PC-relative target, valid/ready on both sides
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_ir/in_pc/in_sel request side;
//        out_valid/out_ready/out_imm/out_target/out_err result side.
module imm_target_gen_pipe #(
  parameter int DATA_W   = 32,
  parameter bit ERR_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ir,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [2:0]        in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_target,
  output logic              out_err
);
  logic              s1_valid, s1_err, err, adv1, adv2;
  logic [2:0]        s1_sel;
  logic [DATA_W-1:0] s1_imm, s1_pc, ext, tgt;
  always_comb begin
    err  = in_sel > 3'd4;
    ext  = in_sel == 3'd0 ? DATA_W'($signed(in_ir[12:0])) :
           in_sel == 3'd1 ? DATA_W'({in_ir[21:0], 10'b0}) :
           in_sel == 3'd2 ? DATA_W'($signed({in_ir[21:0], 2'b00})) :
           in_sel == 3'd3 ? DATA_W'($signed({in_ir[29:0], 2'b00})) :
           in_sel == 3'd4 ? DATA_W'(in_ir[4:0]) :
           ERR_ZERO       ? '0 : DATA_W'(in_ir);
    tgt  = (s1_sel == 3'd2 || s1_sel == 3'd3) ? s1_pc + s1_imm : s1_imm;
    adv2 = !out_valid || out_ready;
    adv1 = !s1_valid || adv2;
  end
  assign in_ready = adv1;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_target <= '0;
      out_err    <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv1 && in_valid) begin
        s1_imm <= ext;
        s1_pc  <= in_pc;
        s1_sel <= in_sel;
        s1_err <= err;
      end
      if (adv2) out_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        out_imm    <= s1_imm;
        out_target <= tgt;
        out_err    <= s1_err;
      end
    end
  end
endmodule

// File: tb/tb_imm_target_gen_pipe.sv
// tb_imm_target_gen_pipe: scoreboard bench driving a 32-bit and a 64-bit instance in lockstep
module tb_imm_target_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt64;
    logic [31:0] tgt32;
    logic        err;
    int          t;
  } exp_t;

  logic        clk, reset, in_valid, out_ready;
  logic [31:0] in_ir;
  logic [63:0] in_pc;
  logic [2:0]  in_sel;
  logic        rdy32, ov32, err32, rdy64, ov64, err64;
  logic [31:0] imm32, tgt32;
  logic [63:0] imm64, tgt64;

  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;
  bit   lat = 0;

  imm_target_gen_pipe #(.DATA_W(32)) d32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_ir(in_ir),
    .in_pc(in_pc[31:0]), .in_sel(in_sel), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_target(tgt32), .out_err(err32));

  imm_target_gen_pipe #(.DATA_W(64)) d64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in_ir(in_ir),
    .in_pc(in_pc), .in_sel(in_sel), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_target(tgt64), .out_err(err64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] s, input logic [31:0] ir, input logic [63:0] pc, input int t);
    exp_t e;
    logic [63:0] v;
    case (s)
      3'd0: v = {{51{ir[12]}}, ir[12:0]};
      3'd1: v = {32'b0, ir[21:0], 10'b0};
      3'd2: v = {{40{ir[21]}}, ir[21:0], 2'b00};
      3'd3: v = {{32{ir[29]}}, ir[29:0], 2'b00};
      3'd4: v = {59'b0, ir[4:0]};
      default: v = '0;
    endcase
    e.imm   = v;
    e.err   = s > 3'd4;
    e.t     = t;
    e.tgt64 = (s == 3'd2 || s == 3'd3) ? pc + v : v;
    e.tgt32 = (s == 3'd2 || s == 3'd3) ? pc[31:0] + v[31:0] : v[31:0];
    return e;
  endfunction

  // One cycle: drive after the falling edge, sample mid-phase, then move to the next falling edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [31:0] ir,
                      input logic [63:0] pc, input logic ordy, output logic acc);
    exp_t e;
    in_valid = v; in_sel = s; in_ir = ir; in_pc = pc; out_ready = ordy;
    #1;
    acc = in_valid && rdy32;
    chk("in_ready_match", {63'b0, rdy64}, {63'b0, rdy32});
    if (ov32 || ov64) begin
      if (q.size() == 0) chk("stale_out", {62'b0, ov64, ov32}, 64'd0);
      else begin
        e = q[0];
        chk("out_valid_match", {63'b0, ov64}, {63'b0, ov32});
        chk("imm32", {32'b0, imm32}, {32'b0, e.imm[31:0]});
        chk("tgt32", {32'b0, tgt32}, {32'b0, e.tgt32});
        chk("err32", {63'b0, err32}, {63'b0, e.err});
        chk("imm64", imm64, e.imm);
        chk("tgt64", tgt64, e.tgt64);
        chk("err64", {63'b0, err64}, {63'b0, e.err});
        if (lat) chk("latency", 64'(cyc - e.t), 64'd2);
        if (ordy) void'(q.pop_front());
      end
    end
    if (acc) q.push_back(model(s, ir, pc, cyc));
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 3'd0, 32'd0, 64'd0, ordy, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) idle(1'b1);
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  task automatic one(input string tag, input logic [2:0] s, input logic [31:0] ir, input logic [63:0] pc,
                     input logic [31:0] ei, input logic [31:0] et, input logic ee, input logic [31:0] ehi);
    logic a;
    step(1'b1, s, ir, pc, 1'b1, a);
    chk({tag, "_acc"}, {63'b0, a}, 64'd1);
    idle(1'b1);
    chk({tag, "_valid"}, {63'b0, ov32}, 64'd1);
    chk({tag, "_imm"}, {32'b0, imm32}, {32'b0, ei});
    chk({tag, "_tgt"}, {32'b0, tgt32}, {32'b0, et});
    chk({tag, "_err"}, {63'b0, err32}, {63'b0, ee});
    chk({tag, "_imm64_hi"}, {32'b0, imm64[63:32]}, {32'b0, ehi});
    idle(1'b1);
  endtask

  initial begin
    logic        a;
    int          n;
    logic [2:0]  bs [4];
    logic [31:0] bi [4];
    clk = 0; reset = 1; in_valid = 0; in_ir = 0; in_pc = 0; in_sel = 0; out_ready = 0;
    bs = '{3'd0, 3'd2, 3'd3, 3'd4};
    bi = '{32'h0000_1ABC, 32'h0012_3456, 32'h2000_0101, 32'h0000_0017};
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_out_valid", {62'b0, ov64, ov32}, 64'd0);
    chk("rst_imm", {32'b0, imm32}, 64'd0);
    chk("rst_tgt", {32'b0, tgt32}, 64'd0);
    chk("rst_err", {62'b0, err64, err32}, 64'd0);
    chk("rst_in_ready", {63'b0, rdy32}, 64'd1);

    lat = 1;
    one("sel0", 3'd0, 32'h0000_1FFF, 64'h1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
    one("sel1", 3'd1, 32'h003F_FFFF, 64'h1000, 32'hFFFF_FC00, 32'hFFFF_FC00, 1'b0, 32'h0);
    one("sel2", 3'd2, 32'h0020_0000, 64'h1000, 32'hFF80_0000, 32'hFF80_1000, 1'b0, 32'hFFFF_FFFF);
    one("sel3", 3'd3, 32'h0000_0010, 64'h1000, 32'h0000_0040, 32'h0000_1040, 1'b0, 32'h0);
    one("sel4", 3'd4, 32'hFFFF_FFFF, 64'h1000, 32'h0000_001F, 32'h0000_001F, 1'b0, 32'h0);
    one("sel6", 3'd6, 32'hFFFF_FFFF, 64'h1000, 32'h0, 32'h0, 1'b1, 32'h0);
    one("after_rsvd", 3'd0, 32'h0000_0001, 64'h1000, 32'h1, 32'h1, 1'b0, 32'h0);
    one("wrap", 3'd3, 32'h0000_0004, 64'hFFFF_FFF0, 32'h10, 32'h0, 1'b0, 32'h0);
    one("disp30_neg", 3'd3, 32'h2000_0000, 64'h1000, 32'h8000_0000, 32'h8000_1000, 1'b0, 32'hFFFF_FFFF);
    lat = 0;

    n = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, bs[n], bi[n], 64'h2000, 1'b0, a);
      chk("bp_acc", {63'b0, a}, {63'b0, k < 2});
      if (a) n++;
    end
    chk("bp_captured", 64'(n), 64'd2);
    for (int k = 0; k < 20 && (n < 4 || q.size() > 0); k++) begin
      if (n < 4) begin
        step(1'b1, bs[n], bi[n], 64'h2000, 1'b1, a);
        if (a) n++;
      end else idle(1'b1);
    end
    chk("bp_all_sent", 64'(n), 64'd4);
    chk("bp_all_recv", 64'(q.size()), 64'd0);

    step(1'b1, 3'd2, 32'h0000_0005, 64'h3000, 1'b0, a);
    step(1'b1, 3'd0, 32'h0000_0123, 64'h3000, 1'b0, a);
    chk("full_in_ready", {63'b0, rdy32}, 64'd0);
    reset = 1;
    in_valid = 0;
    @(negedge clk);
    cyc++;
    reset = 0;
    q.delete();
    #1;
    chk("midrst_out_valid", {62'b0, ov64, ov32}, 64'd0);
    chk("midrst_in_ready", {63'b0, rdy32}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("post_rst_idle", {62'b0, ov64, ov32}, 64'd0);
    end

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0), a);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_target_gen_pipe.md
Name: imm_target_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate/displacement extender.
- Extracts one of five immediate formats from a SPARC V8 instruction word and sign/zero-extends it to DATA_W. For displacement formats it also forms the PC-relative branch/call target.
- Sits between decode and execute/fetch-redirect.
- Two-stage pipeline with valid/ready handshake on both sides, so decode can be stalled by downstream back-pressure.

Parameters:
- DATA_W, 32, datapath width of the immediate and target outputs; legal values are ≥ 32.
- ERR_ZERO, 1, when 1 a reserved mode drives out_imm and out_target to zero; when 0 the stage-1 value passes through unchanged.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid request.
- in_ready  out  1  block accepts a request this cycle.
- in_ir  in  32  instruction word.
- in_pc  in  DATA_W  address of the instruction.
- in_sel  in  3  format select: 0 simm13, 1 sethi imm22, 2 disp22, 3 disp30, 4 shcnt; 5–7 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_imm  out  DATA_W  extended immediate.
- out_target  out  DATA_W  in_pc + out_imm for sel 2/3; otherwise equals out_imm.
- out_err  out  1  request used a reserved in_sel.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - out_imm, out_target and out_err = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Extension rules, all in stage 1:
  - sel 0: sign-extend IR[12:0] to DATA_W.
  - sel 1: IR[21:0] placed at bits [31:10], bits [9:0] = 0, bits above 31 = 0.
  - sel 2: sign-extend IR[21:0], then shift left by 2 (bits [1:0] = 0).
  - sel 3: {IR[29:0], 2'b00} forms bits [31:0]. For DATA_W > 32 it is sign-extended from bit 31; for DATA_W = 32 there is no extension.
  - sel 4: zero-extend IR[4:0].
  - sel 5–7: err = 1; value per ERR_ZERO.
- Stage 1 registers the extended value, pc, sel and err.
- Stage 2 computes the target:
  - sel 2/3: target = pc + imm, modulo 2^DATA_W; wrap-around is silent, no carry out.
  - Other sel: target = imm.
  - Stage 2 registers imm, target and err onto the outputs.
- Latency: 2 cycles from accept to out_valid with no stalls. Throughput is 1 request per cycle.
- Handshake, standard valid/ready:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is combinational from out_ready and the stage valids; there is no path from in_valid to in_ready.
- Bubbles collapse: a valid stage 1 moves into an empty stage 2 even while out_ready = 0.
- Outputs stay stable while out_valid && !out_ready, and must not change until accepted.
- Simultaneous events:
  - Accept in, advance stage 1 and drain out can all happen in one cycle. No request is lost or duplicated.
  - With both stages full and out_ready = 0: in_ready = 0 and the in_* inputs are ignored.
- Reset mid-operation: both stage valids clear on the next edge and in-flight requests are discarded. out_valid is 0 the cycle after reset regardless of out_ready.
- in_ir bits outside the selected field are ignored; in_pc is ignored for sel ≠ 2/3.

Test Plan:
- Mode sweep, DATA_W = 32, out_ready = 1, in_pc = 0x0000_1000:
  - sel 0, IR[12:0] = 0x1FFF → imm = 0xFFFF_FFFF.
  - sel 1, IR[21:0] = 0x3FFFFF → imm = 0xFFFF_FC00.
  - sel 2, IR[21:0] = 0x200000 → imm = 0xFF80_0000, target = 0xFF80_1000.
  - sel 3, IR[29:0] = 0x0000_0010 → imm = 0x40, target = 0x1040.
  - sel 4, IR = 0xFFFF_FFFF → imm = 0x1F.
  - Each result appears exactly 2 cycles after accept.
- Reserved select: sel 6, ERR_ZERO = 1 → out_err = 1, imm = target = 0. Next request sel 0 → out_err = 0.
- Back-pressure: stream 4 requests with out_ready = 0 → 2 captured, in_ready = 0 from the 3rd cycle, outputs frozen. Raise out_ready → results delivered in order, none dropped or duplicated.
- Wrap-around: sel 3, in_pc = 0xFFFF_FFF0, disp30 = 4 → target = 0x0000_0000.
- Reset while both stages are full: assert reset for 1 cycle → out_valid = 0 next cycle, in_ready = 1, no stale result emitted afterwards.
- DATA_W = 64:
  - sel 3, IR[29] = 1 → imm[63:32] = 0xFFFF_FFFF.
  - sel 1 → imm[63:32] = 0.
  - Random streaming under random out_ready, checked against a reference model.
